// File: rtl/kernel_weight_streamer.sv
// kernel_weight_streamer
// -----------------------------------------------------------------------------
// Writer-side engine for the kernel convolution FIFO. A start pulse launches a
// job that reads KERNEL_SIZE weight words per input channel from a weight
// memory with one cycle of read latency. Each returned word is pushed into the
// downstream FIFO. A read is only issued when the FIFO is guaranteed to have
// room for the matching write one cycle later, so the FIFO never overflows.
//
// Optional feature (macro KERNEL_STREAMER_CHECKSUM_EN): adds o_checksum, the
// running sum modulo 2^DATA_WIDTH of every word written in the current job.
//
// Ports:
//   i_clock          clock
//   i_reset          asynchronous active-low reset
//   i_start          1-cycle start pulse, only honoured while idle
//   i_base_addr      address of the first weight word
//   i_num_channels   number of input channels to stream (0 = empty job)
//   o_mem_ren        weight memory read enable
//   o_mem_raddr      weight memory read address
//   i_mem_rdata      weight memory data, valid the cycle after o_mem_ren
//   o_wenable        FIFO write enable
//   o_wdata          FIFO write data
//   i_fifo_full      FIFO full flag
//   i_element_count  FIFO occupancy
//   o_busy           high whenever a job is in progress
//   o_done           1-cycle job completion pulse
//   o_channel_index  channel currently being fetched
//   o_overflow       sticky flag: a write was attempted into a full FIFO
//   o_checksum       (KERNEL_STREAMER_CHECKSUM_EN only) sum of written words
// -----------------------------------------------------------------------------
module kernel_weight_streamer #(
    parameter int DATA_WIDTH          = 32,
    parameter int ADDR_WIDTH          = 16,
    parameter int KERNEL_SIZE         = 9,
    parameter int INPUT_CHANNEL_WIDTH = 8,
    parameter int FIFO_DEPTH          = 16,
    parameter int POINTER_WIDTH       = $clog2(FIFO_DEPTH)
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_start,
    input  logic [ADDR_WIDTH-1:0]          i_base_addr,
    input  logic [INPUT_CHANNEL_WIDTH-1:0] i_num_channels,
    output logic                           o_mem_ren,
    output logic [ADDR_WIDTH-1:0]          o_mem_raddr,
    input  logic [DATA_WIDTH-1:0]          i_mem_rdata,
    output logic                           o_wenable,
    output logic [DATA_WIDTH-1:0]          o_wdata,
    input  logic                           i_fifo_full,
    input  logic [POINTER_WIDTH:0]         i_element_count,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [INPUT_CHANNEL_WIDTH-1:0] o_channel_index,
    output logic                           o_overflow
`ifdef KERNEL_STREAMER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]          o_checksum
`endif
);

    // Credit arithmetic is one bit wider than the element count so that the
    // count plus the in-flight write can never wrap.
    localparam int CW = POINTER_WIDTH + 2;
    localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                          r_state;
    logic [ADDR_WIDTH-1:0]           r_addr;
    logic [INPUT_CHANNEL_WIDTH-1:0]  r_num_ch;
    logic [INPUT_CHANNEL_WIDTH-1:0]  r_channel_index;
    logic [KW-1:0]                   r_word_cnt;
    logic                            r_wenable;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_overflow;

    logic [CW-1:0]                   w_occupancy;
    logic                            w_credit;
    logic                            w_issue;
    logic                            w_last_word;
    logic                            w_last_channel;

    // The word being written this cycle is not yet in the FIFO's count, so it
    // is added back in before deciding whether the next read may be issued.
    assign w_occupancy    = {1'b0, i_element_count} + {{(CW-1){1'b0}}, r_wenable};
    assign w_credit       = w_occupancy < CW'(FIFO_DEPTH);
    assign w_issue        = (r_state == FETCH) && w_credit;
    assign w_last_word    = r_word_cnt == KW'(KERNEL_SIZE - 1);
    assign w_last_channel = r_channel_index == (r_num_ch - INPUT_CHANNEL_WIDTH'(1));

    // Read issue is combinational on the live credit so a stall takes effect
    // in the same cycle the FIFO fills; the address is zero when not reading.
    assign o_mem_ren       = w_issue;
    assign o_mem_raddr     = w_issue ? r_addr : '0;
    assign o_wenable       = r_wenable;
    assign o_wdata         = r_wenable ? i_mem_rdata : '0;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_channel_index = r_channel_index;
    assign o_overflow      = r_overflow;

    // Main job FSM. A zero-channel job still passes through FLUSH so that its
    // completion pulse lands two cycles after start, like the tail of a real
    // job. The channel index holds at the last channel once fetching ends.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_num_ch        <= '0;
            r_channel_index <= '0;
            r_word_cnt      <= '0;
            r_wenable       <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_wenable  <= w_issue;
            r_overflow <= r_overflow | (r_wenable & i_fifo_full);
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_busy          <= 1'b1;
                        r_addr          <= i_base_addr;
                        r_num_ch        <= i_num_channels;
                        r_channel_index <= '0;
                        r_word_cnt      <= '0;
                        r_state         <= (i_num_channels == '0) ? FLUSH : FETCH;
                    end
                end
                FETCH: begin
                    if (w_issue) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        if (w_last_word) begin
                            r_word_cnt <= '0;
                            if (w_last_channel) begin
                                r_state <= FLUSH;
                            end else begin
                                r_channel_index <= r_channel_index + INPUT_CHANNEL_WIDTH'(1);
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + KW'(1);
                        end
                    end
                end
                FLUSH: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef KERNEL_STREAMER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    // Running sum of written words; restarts on an accepted start and stays
    // frozen after the last write until the next job begins.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_checksum <= '0;
        end else if ((r_state == IDLE) && i_start) begin
            r_checksum <= '0;
        end else if (r_wenable) begin
            r_checksum <= r_checksum + i_mem_rdata;
        end
    end

    assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_kernel_weight_streamer.sv
// tb_kernel_weight_streamer
// -----------------------------------------------------------------------------
// Self-checking bench for kernel_weight_streamer. A weight memory model returns
// mem[a] = a one cycle after a read, and a FIFO occupancy model counts writes
// and consumer pops. Expected addresses and words are queued when a job is
// started and checked off as the design reads and writes them.
// -----------------------------------------------------------------------------
module tb_kernel_weight_streamer;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int KS  = 9;
    localparam int ICW = 8;
    localparam int FD  = 16;
    localparam int PW  = 4;

    logic           clk = 1'b0;
    logic           rstN;
    logic           start;
    logic [AW-1:0]  baseAddr;
    logic [ICW-1:0] numCh;
    logic           memRen;
    logic [AW-1:0]  memRaddr;
    logic [DW-1:0]  memRdata = '0;
    logic           wen;
    logic [DW-1:0]  wdata;
    logic           fifoFull;
    logic [PW:0]    elemCount;
    logic           busy;
    logic           done;
    logic [ICW-1:0] chIdx;
    logic           overflow;
`ifdef KERNEL_STREAMER_CHECKSUM_EN
    logic [DW-1:0]  checksum;
`endif

    int cyc        = 0;
    int fifoCount  = 0;
    bit tieZero    = 1'b1;
    bit popReq     = 1'b0;
    bit fifoClear  = 1'b0;

    int errCount   = 0;
    int checkCount = 0;

    int renCount   = 0;
    int writeCount = 0;
    int doneCount  = 0;
    int busyCount  = 0;
    int firstRenCyc = -1;
    int firstWenCyc = -1;
    int lastWenCyc  = -1;
    int doneCyc     = -1;

    int jobRenBase  = 0;
    int jobWrBase   = 0;
    int jobDoneBase = 0;
    int jobBusyBase = 0;
    int startCyc    = 0;

    logic [AW-1:0] addrQ[$];
    logic [DW-1:0] dataQ[$];

    kernel_weight_streamer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .KERNEL_SIZE(KS),
        .INPUT_CHANNEL_WIDTH(ICW), .FIFO_DEPTH(FD), .POINTER_WIDTH(PW)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rstN),
        .i_start         (start),
        .i_base_addr     (baseAddr),
        .i_num_channels  (numCh),
        .o_mem_ren       (memRen),
        .o_mem_raddr     (memRaddr),
        .i_mem_rdata     (memRdata),
        .o_wenable       (wen),
        .o_wdata         (wdata),
        .i_fifo_full     (fifoFull),
        .i_element_count (elemCount),
        .o_busy          (busy),
        .o_done          (done),
        .o_channel_index (chIdx),
        .o_overflow      (overflow)
`ifdef KERNEL_STREAMER_CHECKSUM_EN
        ,
        .o_checksum      (checksum)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Cycle counter, weight memory (mem[a] = a, one cycle latency) and FIFO
    // occupancy model; a pop removes one kernel's worth of words at once.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memRen) memRdata <= DW'(memRaddr);
        if (fifoClear) fifoCount <= 0;
        else fifoCount <= fifoCount + (wen ? 1 : 0) - ((popReq && fifoCount >= KS) ? KS : 0);
    end

    assign elemCount = tieZero ? '0 : fifoCount[PW:0];
    assign fifoFull  = (elemCount == (PW+1)'(FD));

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor on the falling edge: scoreboard reads and writes, record timing.
    always @(negedge clk) begin
        if (busy) busyCount++;
        if (memRen) begin
            if (renCount == jobRenBase) firstRenCyc = cyc;
            renCount++;
            checkOutput("raddrExpected", addrQ.size() != 0, 1);
            if (addrQ.size() != 0) checkOutput("raddr", memRaddr, addrQ.pop_front());
        end
        if (wen) begin
            if (writeCount == jobWrBase) firstWenCyc = cyc;
            lastWenCyc = cyc;
            writeCount++;
            checkOutput("writeWhileFull", fifoFull, 0);
            checkOutput("wdataExpected", dataQ.size() != 0, 1);
            if (dataQ.size() != 0) checkOutput("wdata", wdata, dataQ.pop_front());
        end
        if (done) begin
            doneCount++;
            doneCyc = cyc;
        end
    end

    // Queue the job's expected traffic, then pulse start for one cycle.
    task automatic applyStimulus(input logic [AW-1:0] base, input int ch);
        logic [AW-1:0] a;
        for (int i = 0; i < ch * KS; i++) begin
            a = base + AW'(i);
            addrQ.push_back(a);
            dataQ.push_back(DW'(a));
        end
        jobRenBase  = renCount;
        jobWrBase   = writeCount;
        jobDoneBase = doneCount;
        jobBusyBase = busyCount;
        baseAddr    = base;
        numCh       = ICW'(ch);
        start       = 1'b1;
        startCyc    = cyc;
        @(posedge clk); #2;
        start       = 1'b0;
    endtask

    // Bounded wait for the job's completion pulse, plus a little settle time.
    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (doneCount > jobDoneBase) break;
            @(posedge clk); #2;
        end
        checkOutput("doneSeen", doneCount - jobDoneBase, 1);
        repeat (3) begin @(posedge clk); #2; end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ren"},   memRen, 0);
        checkOutput({tag, "_raddr"}, memRaddr, 0);
        checkOutput({tag, "_wen"},   wen, 0);
        checkOutput({tag, "_wdata"}, wdata, 0);
        checkOutput({tag, "_busy"},  busy, 0);
        checkOutput({tag, "_done"},  done, 0);
        checkOutput({tag, "_chIdx"}, chIdx, 0);
        checkOutput({tag, "_ovf"},   overflow, 0);
    endtask

    initial begin
        logic [DW-1:0] sum;
        rstN     = 1'b0;
        start    = 1'b0;
        baseAddr = '0;
        numCh    = '0;

        // Reset state.
        #12;
        checkIdleOutputs("reset");
        @(posedge clk); #2;
        rstN = 1'b1;
        repeat (2) begin @(posedge clk); #2; end

        // Single channel, credit always available: timing of the stream.
        $display("[TB] single channel stream");
        applyStimulus(16'h0010, 1);
        waitDone(100);
        checkOutput("t1_firstRen", firstRenCyc, startCyc + 1);
        checkOutput("t1_firstWen", firstWenCyc, startCyc + 2);
        checkOutput("t1_writes", writeCount - jobWrBase, 9);
        checkOutput("t1_consecutive", lastWenCyc - firstWenCyc, 8);
        checkOutput("t1_doneAfterLast", doneCyc, lastWenCyc + 1);
        checkOutput("t1_busyCycles", busyCount - jobBusyBase, 11);
        checkOutput("t1_overflow", overflow, 0);

        // Two channels into a depth-16 FIFO with no pops: stall, then resume.
        $display("[TB] credit stall and resume");
        fifoClear = 1'b1;
        @(posedge clk); #2;
        fifoClear = 1'b0;
        tieZero   = 1'b0;
        applyStimulus(16'h0100, 2);
        repeat (30) begin @(posedge clk); #2; end
        checkOutput("t2_stallWrites", writeCount - jobWrBase, 16);
        checkOutput("t2_stallRen", memRen, 0);
        checkOutput("t2_stallCount", elemCount, 16);
        checkOutput("t2_stallChIdx", chIdx, 1);
        checkOutput("t2_stallBusy", busy, 1);
        checkOutput("t2_noEarlyDone", doneCount - jobDoneBase, 0);
        popReq = 1'b1;
        @(posedge clk); #2;
        popReq = 1'b0;
        waitDone(100);
        checkOutput("t2_totalWrites", writeCount - jobWrBase, 18);
        checkOutput("t2_finalCount", elemCount, 9);
        checkOutput("t2_overflow", overflow, 0);
        tieZero = 1'b1;

        // Zero channels: no traffic, done two cycles after start.
        $display("[TB] zero channel job");
        applyStimulus(16'h0500, 0);
        waitDone(20);
        checkOutput("t3_reads", renCount - jobRenBase, 0);
        checkOutput("t3_writes", writeCount - jobWrBase, 0);
        checkOutput("t3_doneCyc", doneCyc, startCyc + 2);
        checkOutput("t3_busyCycles", busyCount - jobBusyBase, 2);

        // Address wrap at the top of the memory.
        $display("[TB] address wrap");
        applyStimulus(16'hFFFE, 1);
        waitDone(100);
        checkOutput("t4_writes", writeCount - jobWrBase, 9);
        checkOutput("t4_queueEmpty", dataQ.size(), 0);

        // Start re-pulsed mid-job and during DONE must be ignored.
        $display("[TB] ignored start pulses");
        applyStimulus(16'h0040, 2);
        repeat (4) begin @(posedge clk); #2; end
        baseAddr = 16'h0300;
        numCh    = 8'd3;
        start    = 1'b1;
        @(posedge clk); #2;
        start    = 1'b0;
        for (int i = 0; i < 100 && cyc < startCyc + 20; i++) begin @(posedge clk); #2; end
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #2; end
        checkOutput("t5_doneCount", doneCount - jobDoneBase, 1);
        checkOutput("t5_doneCyc", doneCyc, startCyc + 20);
        checkOutput("t5_writes", writeCount - jobWrBase, 18);
        checkOutput("t5_idleAfter", busy, 0);

        // Asynchronous reset after four writes of a three-channel job.
        $display("[TB] reset mid-job");
        applyStimulus(16'h0080, 3);
        for (int i = 0; i < 200; i++) begin
            if (writeCount - jobWrBase >= 4) break;
            @(negedge clk); #1;
        end
        checkOutput("t6_fourWrites", writeCount - jobWrBase, 4);
        rstN = 1'b0;
        #1;
        checkIdleOutputs("t6_async");
        repeat (3) @(posedge clk);
        #2;
        rstN = 1'b1;
        repeat (20) begin @(posedge clk); #2; end
        checkOutput("t6_noMoreWrites", writeCount - jobWrBase, 4);
        checkOutput("t6_noDone", doneCount - jobDoneBase, 0);
        addrQ.delete();
        dataQ.delete();

        applyStimulus(16'h0200, 3);
        waitDone(200);
        checkOutput("t6_freshWrites", writeCount - jobWrBase, 27);
        checkOutput("t6_overflow", overflow, 0);
`ifdef KERNEL_STREAMER_CHECKSUM_EN
        sum = '0;
        for (int i = 0; i < 27; i++) sum = sum + DW'(16'h0200 + i);
        checkOutput("t6_checksum", checksum, sum);
`else
        sum = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
